// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble scheduler: FSM encoding, widths,
// selector constants and a helper that replicates one nibble index into all fields.
package nibble_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int NIB_W   = 4;
    localparam int NIB_CNT = 8;
    localparam int SEL_W   = 3;

    localparam logic [SEL_W-1:0] IDX_TOP = SEL_W'(NIB_CNT - 1);

    localparam logic [NIB_W-1:0] SEL_AB_ALL_A = 4'h0;
    localparam logic [NIB_W-1:0] SEL_AB_ALL_B = 4'hF;

    // Every output bit k reads bit k of the same nibble, so all four fields carry idx.
    function automatic logic [NIB_W*SEL_W-1:0] fill_sel(input logic [SEL_W-1:0] idx);
        return {NIB_W{idx}};
    endfunction

endpackage

// File: rtl/nibble_sched_if.sv
// Bus bundle between the requester FIFOs, the nibble datapath and the scheduler.
// Handshake: a word moves on a rising CLK edge where REQ_x & READY_x; READY_x is combinational.
interface nibble_sched_if;
    import nibble_pkg::*;

    logic        REQ_A;
    logic [31:0] DIN_A;
    logic        READY_A;
    logic        REQ_B;
    logic [31:0] DIN_B;
    logic        READY_B;

    logic [31:0] DATA_A;
    logic [31:0] DATA_B;
    logic [11:0] SEL_A;
    logic [11:0] SEL_B;
    logic [3:0]  SEL_AB;
    logic [3:0]  DATA_OUT;

    logic [3:0]  NIB_OUT;
    logic        NIB_VALID;
    logic        NIB_SRC;
    logic        NIB_LAST;

    state_e      DBG_STATE;
    logic [2:0]  DBG_IDX;

    modport master (
        input  REQ_A, DIN_A, REQ_B, DIN_B, DATA_OUT,
        output READY_A, READY_B, DATA_A, DATA_B, SEL_A, SEL_B, SEL_AB,
        output NIB_OUT, NIB_VALID, NIB_SRC, NIB_LAST, DBG_STATE, DBG_IDX
    );

    modport slave (
        output REQ_A, DIN_A, REQ_B, DIN_B, DATA_OUT,
        input  READY_A, READY_B, DATA_A, DATA_B, SEL_A, SEL_B, SEL_AB,
        input  NIB_OUT, NIB_VALID, NIB_SRC, NIB_LAST, DBG_STATE, DBG_IDX
    );

endinterface

// File: rtl/nibble_sched_rr_arb2.sv
// Two-requester round-robin arbiter; after a transfer the pointer favours the loser.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;  // 0 = A, 1 = B

    always_comb begin
        gnt_o = 2'b00;
        if (enable_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
        ptr_d = ptr_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/nibble_sched.sv
// Nibble scheduler: grants one 32-bit word at a time, walks its 8 nibbles MSB first
// through the datapath selectors and tags the datapath result as a nibble stream.
module nibble_sched
    import nibble_pkg::*;
#(
    parameter int DP_LAT = 1
) (
    input  logic           CLK,
    input  logic           RESET_L,
    nibble_sched_if.master bus
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic              src_q, src_d;
    logic [31:0]       data_a_q, data_a_d;
    logic [31:0]       data_b_q, data_b_d;
    logic [11:0]       sel_a_q, sel_a_d;
    logic [11:0]       sel_b_q, sel_b_d;
    logic [3:0]        sel_ab_q, sel_ab_d;

    // {valid, src, last} of the nibble issued this cycle, then delayed to match the datapath.
    logic [2:0]        issue_d, issue_q;
    logic [2:0]        dly_q [DP_LAT];

    logic [1:0]        req, gnt;
    logic              grant_win, xfer, win_b;

    assign req       = {bus.REQ_B, bus.REQ_A};
    assign grant_win = (state_q == IDLE) || (idx_q == '0);

    rr_arb2 u_arb (
        .clk_i     (CLK),
        .rst_ni    (RESET_L),
        .req_i     (req),
        .enable_i  (grant_win),
        .advance_i (xfer),
        .gnt_o     (gnt)
    );

    assign bus.READY_A = gnt[0] & RESET_L;
    assign bus.READY_B = gnt[1] & RESET_L;
    assign xfer        = |(gnt & req) & RESET_L;
    assign win_b       = gnt[1];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_d    = src_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        sel_a_d  = sel_a_q;
        sel_b_d  = sel_b_q;
        sel_ab_d = sel_ab_q;
        if (xfer) begin
            state_d = SHIFT;
            idx_d   = IDX_TOP;
            src_d   = win_b;
            if (win_b) begin
                data_b_d = bus.DIN_B;
                sel_b_d  = fill_sel(IDX_TOP);
                sel_ab_d = SEL_AB_ALL_B;
            end else begin
                data_a_d = bus.DIN_A;
                sel_a_d  = fill_sel(IDX_TOP);
                sel_ab_d = SEL_AB_ALL_A;
            end
        end else if (state_q == SHIFT) begin
            if (idx_q != '0) begin
                idx_d = idx_q - 3'd1;
                if (src_q) begin
                    sel_b_d = fill_sel(idx_d);
                end else begin
                    sel_a_d = fill_sel(idx_d);
                end
            end else begin
                state_d = IDLE;
            end
        end
        issue_d = {state_q == SHIFT, src_q, (state_q == SHIFT) && (idx_q == '0)};
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q  <= IDLE;
            idx_q    <= IDX_TOP;
            src_q    <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            sel_ab_q <= '0;
            issue_q  <= '0;
            for (int i = 0; i < DP_LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_q    <= src_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            sel_ab_q <= sel_ab_d;
            issue_q  <= issue_d;
            dly_q[0] <= issue_q;
            for (int i = 1; i < DP_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign bus.DATA_A    = data_a_q;
    assign bus.DATA_B    = data_b_q;
    assign bus.SEL_A     = sel_a_q;
    assign bus.SEL_B     = sel_b_q;
    assign bus.SEL_AB    = sel_ab_q;
    assign bus.NIB_OUT   = bus.DATA_OUT;
    assign bus.NIB_VALID = dly_q[DP_LAT-1][2];
    assign bus.NIB_SRC   = dly_q[DP_LAT-1][1];
    assign bus.NIB_LAST  = dly_q[DP_LAT-1][0];
    assign bus.DBG_STATE = state_q;
    assign bus.DBG_IDX   = idx_q;

endmodule
